// File: rtl/vga_pkg.sv
// Shared VGA definitions: 800x600 timing constants, RGB444 pixel type and
// the pixel feeder state encoding.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FRONT  = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BACK   = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 600;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BACK   = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/vga_pixel_feeder_sync_fifo.sv
// Synchronous FIFO with show-ahead head, push/pop/flush and occupancy output.
module sync_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             MAX10_CLK1_50,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // The feeder's issue rule reserves a slot for every word in flight.
  a_no_overflow: assert property (@(posedge MAX10_CLK1_50) disable iff (RESET)
    !(do_push && full && !do_pop));

endmodule

// File: rtl/vga_pixel_feeder.sv
// Framebuffer prefetcher feeding one RGB444 pixel per request to the VGA timing stage.
// Optional VGA_FEEDER_UFLOW_CNT_EN adds a saturating underflow counter output uflow_cnt.
//
//   state | meaning
//   IDLE  | no reads, waiting for the first frame_start
//   FILL  | prefetching after a flush until the FIFO is full
//   RUN   | steady streaming, topping up the FIFO as pixels are consumed
module vga_pixel_feeder
  import vga_pkg::*;
#(
  parameter  int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter  int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter  int ADDR_W      = 19,
  parameter  int PIX_W       = 12,
  parameter  int FIFO_DEPTH  = 16,
  parameter  int MEM_LATENCY = 2,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              underflow,
  output logic [LVL_W-1:0]  fifo_level
`ifdef VGA_FEEDER_UFLOW_CNT_EN
  ,
  output logic [15:0]       uflow_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  feeder_state_t          state_q;
  feeder_state_t          state_d;
  logic [ADDR_W-1:0]      addr_q;
  logic [LVL_W-1:0]       inflight_q;
  logic [LVL_W-1:0]       drop_q;
  logic [MEM_LATENCY-1:0] ret_sr;
  logic                   ret;
  logic                   issue;
  logic                   space;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   underflow_evt;
  logic [PIX_W-1:0]       fifo_head;

  assign ret           = ret_sr[MEM_LATENCY-1];
  assign space         = ({1'b0, fifo_level} + {1'b0, inflight_q}) < (LVL_W + 1)'(FIFO_DEPTH);
  assign fifo_push     = ret && (drop_q == '0);
  assign fifo_pop      = pix_req && !frame_start && !fifo_empty;
  assign underflow_evt = pix_req && !frame_start && fifo_empty;
  assign mem_rd        = issue;
  assign mem_addr      = addr_q;

  // frame_start flushes in every state; in IDLE there is nothing to flush.
  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .RESET         (RESET),
    .push          (fifo_push),
    .pop           (fifo_pop),
    .flush         (frame_start),
    .din           (mem_rdata),
    .head          (fifo_head),
    .empty         (fifo_empty),
    .full          (fifo_full),
    .level         (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: if (frame_start) state_d = FILL;
      FILL: begin
        if (frame_start) begin
          state_d = FILL;
        end else begin
          issue = space;
          if (fifo_full) state_d = RUN;
        end
      end
      RUN: begin
        if (frame_start) state_d = FILL;
        else             issue   = space;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      ret_sr     <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_sr     <= (ret_sr << 1) | MEM_LATENCY'(issue);
      inflight_q <= inflight_q + LVL_W'(issue) - LVL_W'(ret);
      pix_valid  <= pix_req;
      if (pix_req) pix_data <= (frame_start || fifo_empty) ? '0 : fifo_head;
      if (frame_start) begin
        // A word returning on the flush cycle is already discarded by the flush.
        addr_q    <= '0;
        drop_q    <= inflight_q - LVL_W'(ret);
        underflow <= 1'b0;
      end else begin
        if (issue) addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        if (ret && (drop_q != '0)) drop_q <= drop_q - LVL_W'(1);
        if (underflow_evt) underflow <= 1'b1;
      end
    end
  end

`ifdef VGA_FEEDER_UFLOW_CNT_EN
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      uflow_cnt <= '0;
    end else if (underflow_evt && (uflow_cnt != 16'hFFFF)) begin
      uflow_cnt <= uflow_cnt + 16'd1;
    end
  end
`endif

endmodule
